pipe_add_sub: RTL and testbench

//  Parametrised, pipelined add/subtract unit; generalises the 8-bit add_sub

---
 rtl/pipe_add_sub_if.sv | 36 +++
 rtl/pipe_add_sub.sv | 125 ++++++++++++
 tb/tb_pipe_add_sub.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_add_sub_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_sub_if
//  Description : Operand/result handshake bundle for the pipelined
//                add/subtract unit. The master drives operands and consumes
//                results; the slave is the arithmetic unit itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero, out_neg
  );
endinterface
`default_nettype wire

// File: rtl/pipe_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_sub
//  Description : Pipelined WIDTH-bit add/subtract unit (ADD/SUB/ADC/SBB).
//                The operands are split into STAGES chunks of WIDTH/STAGES
//                bits; stage k adds chunk k using the carry registered by
//                stage k-1. Unconsumed operand chunks travel forward with the
//                beat, finished sum chunks accumulate behind it. A single
//                global stall freezes every stage when the result is blocked.
//                WIDTH must be a multiple of STAGES.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_add_sub_if.slave bus
);

  localparam int c_cw   = WIDTH / STAGES;
  localparam int c_last = STAGES - 1;

  logic             w_advance;
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;

  // Whole pipe moves only when the output slot is empty or being drained.
  assign w_advance    = !g_stage[c_last].r_v || bus.out_ready;
  assign bus.in_ready = w_advance && !rst;

  // Subtraction is A + ~B + carry; ADD/SUB force the carry, ADC/SBB take cin.
  assign w_b0 = bus.in_op[0] ? ~bus.in_b : bus.in_b;
  assign w_c0 = bus.in_op[1] ? bus.in_cin : bus.in_op[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when the beat enters this stage.
    localparam int c_rem = WIDTH - c_cw * k;

    logic [c_rem-1:0]        w_a;
    logic [c_rem-1:0]        w_b;
    logic                    w_cin;
    logic                    w_zin;
    logic                    w_vin;
    logic [c_cw:0]           w_chunk;
    logic [c_cw*(k+1)-1:0]   w_s;
    logic [c_cw*(k+1)-1:0]   r_s;
    logic                    r_v;
    logic                    r_c;
    logic                    r_z;

    if (k == 0) begin : g_head
      assign w_a   = bus.in_a;
      assign w_b   = w_b0;
      assign w_cin = w_c0;
      assign w_zin = 1'b1;
      assign w_vin = bus.in_valid;
      assign w_s   = w_chunk[c_cw-1:0];
    end else begin : g_body
      assign w_a   = g_stage[k-1].g_fwd.r_a;
      assign w_b   = g_stage[k-1].g_fwd.r_b;
      assign w_cin = g_stage[k-1].r_c;
      assign w_zin = g_stage[k-1].r_z;
      assign w_vin = g_stage[k-1].r_v;
      assign w_s   = {w_chunk[c_cw-1:0], g_stage[k-1].r_s};
    end

    assign w_chunk = {1'b0, w_a[c_cw-1:0]} + {1'b0, w_b[c_cw-1:0]}
                   + {{c_cw{1'b0}}, w_cin};

    // Register this chunk's sum, its carry and the running zero/valid bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_z <= 1'b0;
        r_s <= '0;
      end else if (w_advance) begin
        r_v <= w_vin;
        r_c <= w_chunk[c_cw];
        r_z <= w_zin && (w_chunk[c_cw-1:0] == '0);
        r_s <= w_s;
      end
    end

    if (k < c_last) begin : g_fwd
      logic [c_rem-c_cw-1:0] r_a;
      logic [c_rem-c_cw-1:0] r_b;

      // Skew the upper operand chunks so they meet their carry downstream.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a[c_rem-1:c_cw];
          r_b <= w_b[c_rem-1:c_cw];
        end
      end
    end

    if (k == c_last) begin : g_tail
      logic r_ovf;

      // Overflow is carry into the MSB XOR carry out of the MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= (w_a[c_cw-1] ^ w_b[c_cw-1] ^ w_chunk[c_cw-1]) ^ w_chunk[c_cw];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[c_last].r_v;
  assign bus.out_sum   = g_stage[c_last].r_s;
  assign bus.out_carry = g_stage[c_last].r_c;
  assign bus.out_zero  = g_stage[c_last].r_z;
  assign bus.out_neg   = g_stage[c_last].r_s[WIDTH-1];
  assign bus.out_ovf   = g_stage[c_last].g_tail.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_add_sub
//  Description : Self-checking bench for pipe_add_sub. Directed vector table
//                on a 4-stage build, stall/burst and mid-stream reset
//                sequences, and a random scoreboard on 1- and 32-stage builds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_add_sub;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_add_sub_if #(.WIDTH(WIDTH)) bus   ();
  pipe_add_sub_if #(.WIDTH(WIDTH)) bus1  ();
  pipe_add_sub_if #(.WIDTH(WIDTH)) bus32 ();

  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(4))  dut     (.clk(clk), .rst(rst), .bus(bus));
  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(1))  dut_s1  (.clk(clk), .rst(rst), .bus(bus1));
  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(32)) dut_s32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] sum;
    logic [3:0]  flg;   // {carry, ovf, zero, neg}
  } vec_t;

  localparam int NVEC = 14;
  vec_t vt [NVEC];

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] q1  [$];
  logic [35:0] q32 [$];
  int got1  = 0;
  int got32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: {sum, carry, ovf, zero, neg} from the arithmetic definition.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic cin);
    logic [31:0] bb;
    logic        c0;
    logic [32:0] t;
    logic        v;
    bb = op[0] ? ~b : b;
    c0 = op[1] ? cin : op[0];
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
    v  = (a[31] == bb[31]) && (t[31] != a[31]);
    return {t[31:0], t[32], v, (t[31:0] == 32'd0), t[31]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboards for the 1-stage and 32-stage builds.
  always @(negedge clk) begin : mon1
    logic [35:0] e;
    if (!rst && bus1.out_valid) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL s1_extra: got unexpected beat %0h, expected none", bus1.out_sum);
      end else begin
        e = q1.pop_front();
        chk("s1_result", {bus1.out_sum, bus1.out_carry, bus1.out_ovf, bus1.out_zero, bus1.out_neg}, e);
        got1++;
      end
    end
  end

  always @(negedge clk) begin : mon32
    logic [35:0] e;
    if (!rst && bus32.out_valid) begin
      if (q32.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL s32_extra: got unexpected beat %0h, expected none", bus32.out_sum);
      end else begin
        e = q32.pop_front();
        chk("s32_result", {bus32.out_sum, bus32.out_carry, bus32.out_ovf, bus32.out_zero, bus32.out_neg}, e);
        got32++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] sa [6];
  logic [31:0] sb [6];

  initial begin
    logic [35:0] e;
    logic [35:0] e_in;
    logic [31:0] h_sum;
    logic [3:0]  h_flg;
    logic        held;
    logic        acc;
    int          lat;
    int          i6;
    int          got;
    int          stale;

    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_0000, 4'b1010};
    vt[1]  = '{32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h7FFF_FFFF, 4'b1100};
    vt[2]  = '{32'h0000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'hFFFF_FFFF, 4'b0001};
    vt[3]  = '{32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0001_0000, 4'b0000};
    vt[4]  = '{32'h0000_0001, 32'h0000_0001, 2'b10, 1'b1, 32'h0000_0003, 4'b0000};
    vt[5]  = '{32'h0000_0005, 32'h0000_0003, 2'b11, 1'b0, 32'h0000_0001, 4'b1000};
    vt[6]  = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 32'h8000_0000, 4'b0101};
    vt[7]  = '{32'h0000_0005, 32'h0000_0005, 2'b01, 1'b0, 32'h0000_0000, 4'b1010};
    vt[8]  = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 4'b1010};
    vt[9]  = '{32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 32'hFFFF_FFFF, 4'b0001};
    vt[10] = '{32'h1234_5678, 32'h8765_4321, 2'b00, 1'b0, 32'h9999_9999, 4'b0001};
    vt[11] = '{32'h00FF_00FF, 32'h0000_FFFF, 2'b01, 1'b1, 32'h00FE_0100, 4'b1000};
    vt[12] = '{32'h0000_0005, 32'h0000_0003, 2'b11, 1'b1, 32'h0000_0002, 4'b1000};
    vt[13] = '{32'h0000_00FF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0100, 4'b0000};

    sa = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h0F0F_0F0F, 32'h7FFF_FFFF};
    sb = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h1111_1111, 32'hF0F0_F0F1, 32'h7FFF_FFFF};

    bus.in_valid   = 1'b0; bus.in_a   = '0; bus.in_b   = '0; bus.in_op   = 2'b00; bus.in_cin   = 1'b0; bus.out_ready   = 1'b1;
    bus1.in_valid  = 1'b0; bus1.in_a  = '0; bus1.in_b  = '0; bus1.in_op  = 2'b00; bus1.in_cin  = 1'b0; bus1.out_ready  = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_op = 2'b00; bus32.in_cin = 1'b0; bus32.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_flags", {bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg}, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1);

    // Directed table, one beat at a time; inputs scrambled after accept.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      bus.in_a = vt[i].a; bus.in_b = vt[i].b; bus.in_op = vt[i].op; bus.in_cin = vt[i].cin;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a = ~vt[i].a; bus.in_b = ~vt[i].b; bus.in_op = ~vt[i].op; bus.in_cin = ~vt[i].cin;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk("vec_latency", lat, 4);
      chk("vec_sum", bus.out_sum, vt[i].sum);
      chk("vec_flags", {bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg}, vt[i].flg);
    end

    // Six back-to-back beats with the consumer stalled in cycles 3..5.
    begin
      logic [35:0] sq [$];
      @(posedge clk); #1;
      i6 = 0; got = 0; held = 1'b0; h_sum = '0; h_flg = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        bus.out_ready = !(cyc >= 3 && cyc <= 5);
        if (i6 < 6) begin
          bus.in_valid = 1'b1;
          bus.in_a = sa[i6]; bus.in_b = sb[i6];
          bus.in_op = 2'(i6); bus.in_cin = i6[0];
        end else begin
          bus.in_valid = 1'b0;
        end
        @(negedge clk);
        if (held) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_sum", bus.out_sum, h_sum);
          chk("hold_flags", {bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg}, h_flg);
        end
        held  = bus.out_valid && !bus.out_ready;
        h_sum = bus.out_sum;
        h_flg = {bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg};
        if (bus.out_valid && bus.out_ready) begin
          if (bus.in_valid) chk("full_rate_in_ready", bus.in_ready, 1);
          if (sq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL burst_extra: got unexpected beat %0h, expected none", bus.out_sum);
          end else begin
            e = sq.pop_front();
            chk("burst_result", {bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg}, e);
            got++;
          end
        end
        acc  = bus.in_valid && bus.in_ready;
        e_in = model(bus.in_a, bus.in_b, bus.in_op, bus.in_cin);
        @(posedge clk); #1;
        if (acc) begin
          sq.push_back(e_in);
          i6++;
        end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("burst_count", got, 6);
    end

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'(k + 10); bus.in_b = 32'd1; bus.in_op = 2'b00;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_sum", bus.out_sum, 0);
    chk("midrst_in_ready_after", bus.in_ready, 1);
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    // Random scoreboard on the 1-stage and 32-stage builds.
    @(posedge clk); #1;
    for (int n = 0; n < 1000; ) begin
      logic v;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;
      logic        rc;
      v   = ($urandom_range(0, 3) != 0);
      ra  = pick();
      rb  = pick();
      rop = 2'($urandom_range(0, 3));
      rc  = 1'($urandom_range(0, 1));
      bus1.in_valid  = v; bus1.in_a  = ra; bus1.in_b  = rb; bus1.in_op  = rop; bus1.in_cin  = rc;
      bus32.in_valid = v; bus32.in_a = ra; bus32.in_b = rb; bus32.in_op = rop; bus32.in_cin = rc;
      @(posedge clk); #1;
      if (v) begin
        q1.push_back(model(ra, rb, rop, rc));
        q32.push_back(model(ra, rb, rop, rc));
        n++;
      end
    end
    bus1.in_valid  = 1'b0;
    bus32.in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("s1_drained", q1.size(), 0);
    chk("s32_drained", q32.size(), 0);
    chk("s1_count", got1, 1000);
    chk("s32_count", got32, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
